// File: rtl/gpio_edge_meter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_edge_meter
// Brief    : Multi-channel rising-edge rate meter with gated snapshots,
//            activity LEDs, heartbeat and a muxed count readout.
// Revision : 1.0  initial release
// ============================================================================
module gpio_edge_meter #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 48000000,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   sig_in,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] count_out,
  output logic             ovf_out,
  output logic             valid,
  output logic [NCH-1:0]   active,
  output logic             heartbeat
);

  localparam int                  c_GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
  localparam int                  c_NSEL      = 2 ** SEL_W;

  logic [c_GATE_W-1:0]    r_gate;
  logic                   w_wend;
  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [NCH-1:0]         r_prev;
  logic [NCH-1:0]         w_edge;
  logic [NCH-1:0]         w_hit;
  logic [NCH-1:0]         r_ovf;
  logic [NCH-1:0]         r_snap_ovf;
  logic [CNT_W-1:0]       r_run     [NCH];
  logic [CNT_W-1:0]       w_run_inc [NCH];
  logic [CNT_W-1:0]       r_snap    [NCH];
  logic [CNT_W-1:0]       w_rd_cnt  [c_NSEL];
  logic [c_NSEL-1:0]      w_rd_ovf;

  assign w_wend = (r_gate == c_GATE_LAST);

  // The readout mux looks at the next-state snapshot so count_out lands together with valid.
  always_comb begin
    w_edge    = '0;
    w_hit     = '0;
    w_run_inc = '{default: '0};
    w_rd_cnt  = '{default: '0};
    w_rd_ovf  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_edge[i]    = r_sync[i][SYNC_STAGES-1] & ~r_prev[i];
      w_hit[i]     = w_edge[i] & (&r_run[i]);
      w_run_inc[i] = (w_edge[i] & ~(&r_run[i])) ? r_run[i] + 1'b1 : r_run[i];
      w_rd_cnt[i]  = w_wend ? w_run_inc[i] : r_snap[i];
      w_rd_ovf[i]  = w_wend ? (r_ovf[i] | w_hit[i]) : r_snap_ovf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate     <= '0;
      valid      <= 1'b0;
      heartbeat  <= 1'b0;
      active     <= '0;
      count_out  <= '0;
      ovf_out    <= 1'b0;
      r_prev     <= '0;
      r_ovf      <= '0;
      r_snap_ovf <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= '0;
        r_run[i]  <= '0;
        r_snap[i] <= '0;
      end
    end else begin
      r_gate    <= w_wend ? '0 : r_gate + 1'b1;
      valid     <= w_wend;
      count_out <= w_rd_cnt[sel];
      ovf_out   <= w_rd_ovf[sel];
      if (w_wend) begin
        heartbeat <= ~heartbeat;
      end
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], sig_in[i]};
        r_prev[i] <= r_sync[i][SYNC_STAGES-1];
        if (w_wend) begin
          // An edge arriving in the window-end cycle closes out with this window.
          r_snap[i]     <= w_run_inc[i];
          r_snap_ovf[i] <= r_ovf[i] | w_hit[i];
          active[i]     <= |w_run_inc[i];
          r_run[i]      <= '0;
          r_ovf[i]      <= 1'b0;
        end else begin
          r_run[i]      <= w_run_inc[i];
          r_ovf[i]      <= r_ovf[i] | w_hit[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/gpio_edge_meter.md
Name: gpio_edge_meter

Overview:
Parametrised multi-channel edge-rate meter for camera-interface GPIOs such as xclk, pclk, vsync and href. It runs on the internal oscillator clock. Per channel it synchronises the pin, counts rising edges over a fixed gate window, and snapshots the counts at window end. It drives per-channel activity LEDs, a heartbeat, and a muxed count readout for bring-up debug.

Parameters:
NCH, 4, number of monitored input channels (1..16)
CNT_W, 16, per-channel edge counter width (4..32)
GATE_CYCLES, 48000000, gate window length in clk cycles (>=4)
SYNC_STAGES, 2, synchroniser flops per channel (2..3)
SEL_W, 2, width of readout select; must satisfy 2^SEL_W >= NCH

Ports:
clk  in  1  system clock (HFOSC domain)
reset  in  1  synchronous, active-high reset
sig_in  in  NCH  asynchronous monitored pins
sel  in  SEL_W  readout channel select (quasi-static)
count_out  out  CNT_W  latched count of channel sel
ovf_out  out  1  latched overflow flag of channel sel
valid  out  1  one-cycle pulse: new snapshot available
active  out  NCH  bit i = channel i saw >=1 edge in last window
heartbeat  out  1  toggles once per gate window

Behaviour:
- One clock: clk. Reset is synchronous and active-high: every flop is cleared on a clk edge while reset=1.
- Reset values: all sync flops 0, edge-prev regs 0, running counts 0, snapshots 0, overflow flags 0, gate counter 0, valid=0, active=0, heartbeat=0, count_out=0, ovf_out=0.
- Synchroniser: SYNC_STAGES flops per channel. s = last stage. prev = s delayed by one clk. Edge strobe e = s & ~prev.
- Latency: a pin rising before clk edge k gives e=1 in the cycle after edge k+SYNC_STAGES-1. Exactly one strobe per synchronised rising edge. Falling edges are not counted.
- A pin held high through reset release produces exactly one counted edge once the synchroniser fills. This is intended behaviour.
- Gate counter: counts 0..GATE_CYCLES-1 and wraps to 0. The cycle where gate==GATE_CYCLES-1 is the "window end" cycle (W).
- Running count per channel: +1 on e, saturating at 2^CNT_W-1.
- Overflow flag: set when e=1 while the count is already all-ones. It stays sticky until window end.
- At W:
  - snapshot[i] <= running[i] + e[i], saturated. The edge in cycle W belongs to the closing window.
  - snap_ovf[i] <= ovf[i] | (e[i] & running[i] all-ones).
  - running[i] <= 0 and ovf[i] <= 0. No edge is lost or double-counted across the boundary.
  - active[i] <= (saturated snapshot value != 0).
  - heartbeat toggles.
  - valid asserts in the cycle after W, for exactly one cycle.
- Readout: count_out and ovf_out are registered from snapshot[sel] / snap_ovf[sel], giving one cycle of latency after sel or a snapshot changes.
  - sel >= NCH reads 0 with ovf_out=0.
  - When a snapshot updates, count_out shows the new value in the same cycle that valid=1.
- Reset mid-window: the partial count is discarded, snapshots clear, the gate restarts at 0, and no valid pulse is generated for the aborted window.
- First valid after reset occurs exactly GATE_CYCLES+1 cycles after the first clk edge with reset=0.
- Channels are fully independent. Simultaneous edges on all channels in the same cycle are all counted.

Test Plan:
- Reset check (NCH=4, CNT_W=8, GATE_CYCLES=16, SYNC_STAGES=2): hold reset 3 cycles -> all outputs 0; first valid exactly 17 cycles after reset release; heartbeat=1 in the cycle after W.
- Rate count: ch0 toggles every 2 clk (period 4) from window start, sel=0 -> steady-state windows report count_out=4, active[0]=1; idle ch1 reports 0 and active[1]=0.
- Boundary edge: single rising edge timed so e=1 exactly in cycle W -> counted in the closing window (count=1); next window counts 0; no loss or duplication.
- Saturation: CNT_W=4, GATE_CYCLES=64, ch2 edge every 2 cycles (32 edges) -> count_out=15, ovf_out=1 with sel=2; next window with 5 edges -> count 5, ovf 0.
- Reset mid-window: 6 edges on ch3, then reset pulse at gate=10 -> no valid; the following full window with 3 edges reports 3.
- Select/mux: sel sweeps 0..3 after a snapshot with counts {1,2,3,4} -> count_out follows with 1-cycle latency; SEL_W=3, sel=5 -> 0.
